load_data_extender: RTL and testbench
=====================================

# load_data_extender

Multicycle load-data extension unit for the MIPS datapath; successor to the combinational immediate extender, generalised to every load mode and to both byte orders. It captures a load request, waits on the data-memory handshake, then extracts the addressed byte, halfword or word and sign- or zero-extends it to 32 bits. For LWL/LWR it merges the extracted bytes with the old `rt` value. It sits between the memory interface and register-file writeback.

## Interface
- `LITTLE_ENDIAN`, default 1 — 1: byte 0 is `readdata[7:0]`; 0: byte 0 is `readdata[31:24]`.
- `clk`  in  1  — clock.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — request strobe; sampled only in IDLE.
- `opcode`  in  6  — one of LB, LBU, LH, LHU, LW, LWL, LWR.
- `byte_offset`  in  2  — address bits [1:0].
- `rt_old`  in  32  — current `rt` contents; used for LWL/LWR merge and error pass-through.
- `readdata`  in  32  — memory read word.
- `waitrequest`  in  1  — memory stall; data is valid in the WAIT_MEM cycle where it is 0.
- `busy`  out  1  — high in WAIT_MEM and DONE.
- `done`  out  1  — one-cycle pulse; `result` and `addr_error` are valid with it.
- `result`  out  32  — extended or merged load value.
- `addr_error`  out  1  — misaligned LH/LHU/LW; valid with `done`.

## Operation
- FSM states: IDLE, WAIT_MEM, DONE.
- **IDLE**
  - On `start` with a load opcode, capture `opcode`, `byte_offset` and `rt_old` into registers.
  - Aligned request: go to WAIT_MEM.
  - Misaligned request: go directly to DONE with `addr_error`=1 and `result`=`rt_old`.
  - Misaligned means LH/LHU with offset[0]=1, or LW with offset≠0.
  - `start` with a non-load opcode is ignored; the FSM stays in IDLE.
- **WAIT_MEM**
  - Hold while `waitrequest`=1.
  - When `waitrequest`=0, compute `result` from `readdata` and the captured fields, register it, and go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- **Effective offset** `eo` = `byte_offset` when `LITTLE_ENDIAN`=1, else `byte_offset ^ 2'b11`.
- **Lane selection**
  - Byte = `readdata[8*eo +: 8]`.
  - Halfword = `readdata[16*eo[1] +: 16]`.
- **Extension**
  - LB/LH: sign-extend from the lane MSB.
  - LBU/LHU: zero-extend.
  - LW: pass `readdata` through.
- **LWL** (m = `readdata`, r = captured `rt_old`), by `eo`:
  - 0: {m[7:0], r[23:0]}
  - 1: {m[15:0], r[15:0]}
  - 2: {m[23:0], r[7:0]}
  - 3: m
- **LWR**, by `eo`:
  - 0: m
  - 1: {r[31:24], m[31:8]}
  - 2: {r[31:16], m[31:16]}
  - 3: {r[31:8], m[31:24]}
- LWL/LWR never raise `addr_error`.
- `result` holds its last value until the next DONE.

## Timing
- **Reset**: state IDLE; `busy`=0, `done`=0, `result`=0, `addr_error`=0.
- **Reset mid-operation**: IDLE on the next edge; any in-flight `readdata` is discarded and no `done` is produced.
- **Latency**
  - `start` at edge N with `waitrequest`=0 at edge N+1 gives `done` high in cycle N+2.
  - Each stalled cycle adds one cycle.
  - Misaligned request: `done` in cycle N+1.
- `start` while `busy`=1 is ignored; there is no queuing.
- Back-to-back: a new `start` is accepted in the cycle after DONE, so peak throughput is one load per 3 cycles.
- `done` and `result` change only on clock edges.

## Structure
- Shared package holds:
  - opcode constants `OPCODE_LB`, `OPCODE_LBU`, `OPCODE_LH`, `OPCODE_LHU`, `OPCODE_LW`, `OPCODE_LWL`, `OPCODE_LWR`, alongside the existing ALU/immediate opcodes;
  - FSM state enum `load_state_t`.
- Sub-module `load_lane_merge`: purely combinational.
  - Inputs: captured opcode, `eo`, `readdata`, `rt_old`.
  - Output: the 32-bit value.
  - Instantiated once; the top level owns the FSM and the registers.

## Test plan
- LB, offset 3, LITTLE_ENDIAN=1, `readdata`=0x80_12_34_56, no stall → `done` at N+2, `result`=0xFFFFFF80.
- LHU, offset 2, `readdata`=0xBEEF_1234, `waitrequest` high 3 cycles → `done` at N+5, `result`=0x0000BEEF.
- LWL, offset 1, `readdata`=0xAABBCCDD, `rt_old`=0x11223344 → `result`=0xCCDD3344; LWR, offset 1, same inputs → `result`=0x11AABBCC.
- LITTLE_ENDIAN=0, LB, offset 0, `readdata`=0x7F00_0000 → `result`=0x0000007F.
- Misaligned cases:
  - LW, offset 2 → `done` at N+1, `addr_error`=1, `result`=`rt_old`.
  - LH, offset 1 → same response.
  - Next aligned load → `addr_error`=0.
- Reset mid-load:
  - Assert `reset` in WAIT_MEM → IDLE, all outputs 0, no `done`.
  - `start` during DONE → ignored, single `done`.

Source files
------------

// File: rtl/load_data_extender_pkg.sv
// Shared opcode constants and load-unit state type for the MIPS datapath.
package load_data_extender_pkg;

  // ALU / immediate opcodes
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_XORI  = 6'h0E;
  localparam logic [5:0] OPCODE_LUI   = 6'h0F;

  // Load opcodes
  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LWL = 6'h22;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_LWR = 6'h26;

  typedef enum logic [1:0] {
    LOAD_IDLE     = 2'd0,
    LOAD_WAIT_MEM = 2'd1,
    LOAD_DONE     = 2'd2
  } load_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OPCODE_LB)  || (op == OPCODE_LBU) || (op == OPCODE_LH) ||
           (op == OPCODE_LHU) || (op == OPCODE_LW)  || (op == OPCODE_LWL) ||
           (op == OPCODE_LWR);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    return (((op == OPCODE_LH) || (op == OPCODE_LHU)) && off[0]) ||
           ((op == OPCODE_LW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_lane_merge.sv
// Combinational lane extraction, sign/zero extension and LWL/LWR merge.
module load_lane_merge
  import load_data_extender_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  eo,
  input  logic [31:0] readdata,
  input  logic [31:0] rt_old,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = readdata[{eo, 3'b000} +: 8];
    lane_h = readdata[{eo[1], 4'b0000} +: 16];
    value  = readdata;
    case (opcode)
      OPCODE_LB:  value = {{24{lane_b[7]}}, lane_b};
      OPCODE_LBU: value = {24'h000000, lane_b};
      OPCODE_LH:  value = {{16{lane_h[15]}}, lane_h};
      OPCODE_LHU: value = {16'h0000, lane_h};
      // LWL fills from the top down, LWR from the bottom up; rt keeps the rest
      OPCODE_LWL: begin
        case (eo)
          2'd0:    value = {readdata[7:0],  rt_old[23:0]};
          2'd1:    value = {readdata[15:0], rt_old[15:0]};
          2'd2:    value = {readdata[23:0], rt_old[7:0]};
          default: value = readdata;
        endcase
      end
      OPCODE_LWR: begin
        case (eo)
          2'd0:    value = readdata;
          2'd1:    value = {rt_old[31:24], readdata[31:8]};
          2'd2:    value = {rt_old[31:16], readdata[31:16]};
          default: value = {rt_old[31:8],  readdata[31:24]};
        endcase
      end
      default:    value = readdata;
    endcase
  end

endmodule

// File: rtl/load_data_extender.sv
// Multicycle load-data extender: captures a load, waits on memory, then
// returns the extended or merged value with a one-cycle done pulse.
module load_data_extender
  import load_data_extender_pkg::*;
#(
  parameter logic LITTLE_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] rt_old,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        addr_error
);

  load_state_t state;
  logic [5:0]  op_q;
  logic [1:0]  eo_q;
  logic [31:0] rt_q;
  logic [31:0] merged;

  load_lane_merge u_merge (
    .opcode   (op_q),
    .eo       (eo_q),
    .readdata (readdata),
    .rt_old   (rt_q),
    .value    (merged)
  );

  assign busy = (state != LOAD_IDLE);
  assign done = (state == LOAD_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD_IDLE;
      result     <= 32'h0;
      addr_error <= 1'b0;
    end else begin
      case (state)
        LOAD_IDLE: begin
          if (start && is_load(opcode)) begin
            op_q <= opcode;
            // big-endian memory reverses byte numbering within the word
            eo_q <= byte_offset ^ {2{~LITTLE_ENDIAN}};
            rt_q <= rt_old;
            if (is_misaligned(opcode, byte_offset)) begin
              result     <= rt_old;
              addr_error <= 1'b1;
              state      <= LOAD_DONE;
            end else begin
              state <= LOAD_WAIT_MEM;
            end
          end
        end
        LOAD_WAIT_MEM: begin
          if (!waitrequest) begin
            result     <= merged;
            addr_error <= 1'b0;
            state      <= LOAD_DONE;
          end
        end
        LOAD_DONE: state <= LOAD_IDLE;
        default:   state <= LOAD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_data_extender.sv
// Randomized bench for load_data_extender, little- and big-endian instances
// side by side against a byte-addressed reference model.
module tb_load_data_extender;
  import load_data_extender_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, waitrequest;
  logic [5:0]  opcode;
  logic [1:0]  byte_offset;
  logic [31:0] rt_old, readdata;
  logic        busy_le, done_le, err_le, busy_be, done_be, err_be;
  logic [31:0] res_le, res_be;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  load_data_extender #(.LITTLE_ENDIAN(1'b1)) dut_le (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .byte_offset(byte_offset), .rt_old(rt_old), .readdata(readdata),
    .waitrequest(waitrequest), .busy(busy_le), .done(done_le),
    .result(res_le), .addr_error(err_le)
  );

  load_data_extender #(.LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .byte_offset(byte_offset), .rt_old(rt_old), .readdata(readdata),
    .waitrequest(waitrequest), .busy(busy_be), .done(done_be),
    .result(res_be), .addr_error(err_be)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {addr_error, result}, built from the memory's byte numbering
  function automatic logic [32:0] ref_load(input logic [5:0] op, input int off,
                                           input logic [31:0] rt, input logic [31:0] rd,
                                           input bit le);
    logic [7:0]  b[4];
    logic [15:0] h;
    logic [63:0] mask;
    int          eo, v;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = le ? rd[8*i +: 8] : rd[8*(3-i) +: 8];
    eo = le ? off : 3 - off;
    if (((op == OPCODE_LH || op == OPCODE_LHU) && (off % 2 == 1)) ||
        (op == OPCODE_LW && off != 0))
      return {1'b1, rt};
    h = 16'h0;
    if (op == OPCODE_LH || op == OPCODE_LHU)
      h = le ? {b[off+1], b[off]} : {b[off], b[off+1]};
    r = rd;
    case (op)
      OPCODE_LB:  begin v = $signed(b[off]); r = 32'(v); end
      OPCODE_LBU: r = {24'h0, b[off]};
      OPCODE_LH:  begin v = $signed(h); r = 32'(v); end
      OPCODE_LHU: r = {16'h0, h};
      OPCODE_LWL: begin
        mask = 64'hFFFF_FFFF >> (8 * (eo + 1));
        r = 32'(({32'h0, rd} << (8 * (3 - eo))) | ({32'h0, rt} & mask));
      end
      OPCODE_LWR: begin
        mask = 64'hFFFF_FFFF >> (8 * eo);
        r = (rd >> (8 * eo)) | (rt & ~mask[31:0]);
      end
      default:    r = rd;
    endcase
    return {1'b0, r};
  endfunction

  task automatic run_load(input logic [5:0] op, input logic [1:0] off, input logic [31:0] rt,
                          input logic [31:0] rd, input int stalls, input string tag);
    logic [32:0] exp_le, exp_be;
    int          edges, exp_lat;
    exp_le  = ref_load(op, int'(off), rt, rd, 1'b1);
    exp_be  = ref_load(op, int'(off), rt, rd, 1'b0);
    exp_lat = exp_le[32] ? 1 : 2 + stalls;
    @(negedge clk);
    start = 1'b1; opcode = op; byte_offset = off; rt_old = rt;
    waitrequest = 1'b1; readdata = $urandom;
    @(posedge clk); #1;
    start = 1'b0; opcode = 6'($urandom); byte_offset = 2'($urandom); rt_old = $urandom;
    edges = 1;
    while (!done_le && edges < 40) begin
      waitrequest = (edges - 1 < stalls);
      readdata    = waitrequest ? $urandom : rd;
      @(posedge clk); #1;
      edges++;
    end
    check_eq({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check_eq({tag, "_done_be"}, 32'(done_be), 32'd1);
    check_eq({tag, "_res_le"}, res_le, exp_le[31:0]);
    check_eq({tag, "_err_le"}, 32'(err_le), 32'(exp_le[32]));
    check_eq({tag, "_res_be"}, res_be, exp_be[31:0]);
    check_eq({tag, "_err_be"}, 32'(err_be), 32'(exp_be[32]));
    // a request presented during DONE must be dropped
    start = 1'b1; opcode = OPCODE_LW; byte_offset = 2'd0; waitrequest = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_single_done"}, 32'(done_le), 32'd0);
    check_eq({tag, "_idle_after"}, 32'({busy_le, busy_be}), 32'd0);
  endtask

  logic [5:0] ops[7] = '{OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU,
                         OPCODE_LW, OPCODE_LWL, OPCODE_LWR};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; waitrequest = 1'b0;
    opcode = 6'h0; byte_offset = 2'd0; rt_old = 32'h0; readdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'({busy_le, busy_be}), 32'd0);
    check_eq("reset_done", 32'({done_le, done_be}), 32'd0);
    check_eq("reset_result", res_le | res_be, 32'h0);
    check_eq("reset_err", 32'({err_le, err_be}), 32'd0);
    reset = 1'b0;

    run_load(OPCODE_LB, 2'd3, 32'h5555_AAAA, 32'h8012_3456, 0, "lb_off3");
    check_eq("lb_off3_value", res_le, 32'hFFFF_FF80);
    run_load(OPCODE_LHU, 2'd2, 32'h0, 32'hBEEF_1234, 3, "lhu_stall3");
    check_eq("lhu_stall3_value", res_le, 32'h0000_BEEF);
    run_load(OPCODE_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 0, "lwl_off1");
    check_eq("lwl_off1_value", res_le, 32'hCCDD_3344);
    run_load(OPCODE_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 1, "lwr_off1");
    check_eq("lwr_off1_value", res_le, 32'h11AA_BBCC);
    run_load(OPCODE_LB, 2'd0, 32'h0, 32'h7F00_0000, 0, "lb_be_off0");
    check_eq("lb_be_off0_value", res_be, 32'h0000_007F);
    run_load(OPCODE_LW, 2'd2, 32'hCAFE_F00D, 32'h1234_5678, 0, "lw_misal");
    check_eq("lw_misal_value", res_le, 32'hCAFE_F00D);
    check_eq("lw_misal_err", 32'(err_le), 32'd1);
    run_load(OPCODE_LH, 2'd1, 32'h0BAD_BEEF, 32'h1234_5678, 0, "lh_misal");
    check_eq("lh_misal_err", 32'(err_le), 32'd1);
    run_load(OPCODE_LW, 2'd0, 32'h0BAD_BEEF, 32'h1234_5678, 2, "lw_aligned");
    check_eq("lw_aligned_err", 32'(err_le), 32'd0);

    // non-load opcode is ignored
    @(negedge clk);
    start = 1'b1; opcode = OPCODE_ADDI; byte_offset = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("nonload_busy", 32'(busy_le), 32'd0);
    seen = 0;
    repeat (3) begin @(posedge clk); #1; seen += int'(done_le); end
    check_eq("nonload_no_done", 32'(seen), 32'd0);

    // reset while waiting on memory
    @(negedge clk);
    start = 1'b1; opcode = OPCODE_LW; byte_offset = 2'd0; waitrequest = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("midreset_busy_before", 32'(busy_le), 32'd1);
    reset = 1'b1; waitrequest = 1'b0; readdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_eq("midreset_busy", 32'({busy_le, busy_be}), 32'd0);
    check_eq("midreset_done", 32'({done_le, done_be}), 32'd0);
    check_eq("midreset_result", res_le | res_be, 32'h0);
    check_eq("midreset_err", 32'({err_le, err_be}), 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (3) begin @(posedge clk); #1; seen += int'(done_le | done_be); end
    check_eq("midreset_no_done", 32'(seen), 32'd0);

    for (int i = 0; i < 150; i++)
      run_load(ops[$urandom_range(0, 6)], 2'($urandom_range(0, 3)), $urandom, $urandom,
               $urandom_range(0, 3), $sformatf("rand%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
